braid_collect_ctrl: RTL and testbench

BRAID_COLLECT_CTRL -- requirements
Module: braid_collect_ctrl

---
 rtl/braid_collect_ctrl.sv | 164 ++++++++++++++++
 tb/tb_braid_collect_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/braid_collect_ctrl.sv
// Braid output collection sweep: opens each lane valve in turn, waits for the stream to settle,
// samples the detector and hands the reading downstream. `BRAID_COLLECT_FLUSH_EN adds an inter-lane flush.
module braid_collect_ctrl #(
   parameter int LANES         = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int DATA_W        = 8,
   parameter int FLUSH_CYCLES  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   output logic [LANES-1:0]         valve_o,
   output logic                     flush_o,
   output logic                     det_req,
   input  logic                     det_ack,
   input  logic [DATA_W-1:0]        det_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(LANES)-1:0] rd_lane,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     busy,
   output logic                     done
);

   localparam int LANE_W  = $clog2(LANES);
   // One down-counter serves both settle and flush timing, so size it for the longer of the two.
   localparam int CNT_MAX = (SETTLE_CYCLES > FLUSH_CYCLES) ? SETTLE_CYCLES : FLUSH_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      PUSH,
      FINISH
`ifdef BRAID_COLLECT_FLUSH_EN
      , FLUSH
`endif
   } state_t;

   state_t              state;
   logic [LANE_W-1:0]   lane;
   logic [CNT_W-1:0]    cnt;

   function automatic logic [LANES-1:0] lane_mask(input logic [LANE_W-1:0] l);
      return {{(LANES-1){1'b0}}, 1'b1} << l;
   endfunction

`ifdef BRAID_COLLECT_FLUSH_EN
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   logic flush_q;
   assign flush_o = flush_q;
`else
   assign flush_o = 1'b0;
`endif

   // NOTE: every output is a register updated in this one block with non-blocking assignments,
   // so outputs change only on the clock edge (or immediately on reset) and never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         lane     <= '0;
         cnt      <= '0;
         valve_o  <= '0;
         det_req  <= 1'b0;
         rd_valid <= 1'b0;
         rd_lane  <= '0;
         rd_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef BRAID_COLLECT_FLUSH_EN
         flush_q  <= 1'b0;
`endif
      end else if (abort && state != IDLE) begin
         // Abort outranks every other input and drops all drives without a done pulse.
         state    <= IDLE;
         lane     <= '0;
         cnt      <= '0;
         valve_o  <= '0;
         det_req  <= 1'b0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef BRAID_COLLECT_FLUSH_EN
         flush_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= SETTLE;
                  lane    <= '0;
                  valve_o <= lane_mask('0);
                  cnt     <= SETTLE_LOAD;
                  busy    <= 1'b1;
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state   <= SAMPLE;
                  det_req <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SAMPLE: begin
               if (det_ack) begin
                  state    <= PUSH;
                  det_req  <= 1'b0;
                  rd_valid <= 1'b1;
                  rd_lane  <= lane;
                  rd_data  <= det_data;
               end
            end
            PUSH: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  if (lane < LAST_LANE) begin
                     lane    <= lane + 1'b1;
`ifdef BRAID_COLLECT_FLUSH_EN
                     state   <= FLUSH;
                     valve_o <= '0;
                     flush_q <= 1'b1;
                     cnt     <= FLUSH_LOAD;
`else
                     state   <= SETTLE;
                     valve_o <= lane_mask(lane + 1'b1);
                     cnt     <= SETTLE_LOAD;
`endif
                  end else begin
                     state   <= FINISH;
                     valve_o <= '0;
                     done    <= 1'b1;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
`ifdef BRAID_COLLECT_FLUSH_EN
            FLUSH: begin
               // lane already points at the next lane here.
               if (cnt == '0) begin
                  state   <= SETTLE;
                  flush_q <= 1'b0;
                  valve_o <= lane_mask(lane);
                  cnt     <= SETTLE_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_braid_collect_ctrl.sv
// Randomized scoreboard bench for braid_collect_ctrl: a detector/consumer model drives the DUT,
// expected lane results are queued per sweep and a negedge monitor checks them as they emerge.
module tb_braid_collect_ctrl;

   localparam int LANES         = 4;
   localparam int SETTLE_CYCLES = 16;
   localparam int DATA_W        = 8;
   localparam int FLUSH_CYCLES  = 4;
   localparam int LW            = $clog2(LANES);

   logic              clk;
   logic              rst;
   logic              start;
   logic              abort;
   logic [LANES-1:0]  valve_o;
   logic              flush_o;
   logic              det_req;
   logic              det_ack;
   logic [DATA_W-1:0] det_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [LW-1:0]     rd_lane;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;

   braid_collect_ctrl #(
      .LANES(LANES), .SETTLE_CYCLES(SETTLE_CYCLES), .DATA_W(DATA_W), .FLUSH_CYCLES(FLUSH_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .valve_o(valve_o), .flush_o(flush_o),
      .det_req(det_req), .det_ack(det_ack), .det_data(det_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_lane(rd_lane), .rd_data(rd_data),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int lane;
      int data;
   } exp_t;

   exp_t              exp_q[$];
   int                n_checks = 0;
   int                n_fails  = 0;
   int                done_cnt = 0;
   logic [DATA_W-1:0] sweep_data [LANES];
   int                ready_mode = 0;   // 0: always ready, 1: random, 2: held low
   int                ack_delay  = -1;  // <0: random detector latency
   bit                noise_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string name);
      check(name, {valve_o, flush_o, det_req, rd_valid, busy, done, rd_lane, rd_data}, 0);
   endtask

   // Consumer: rd_ready policy chosen by the test sequence.
   initial begin
      rd_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rd_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // Detector: answers the n-th request of a sweep with sweep_data[n]; optionally sprays
   // spurious acks with junk data while no request is pending.
   initial begin
      int delay_left;
      int req_idx;
      delay_left = -1;
      req_idx    = 0;
      det_ack    = 1'b0;
      det_data   = '0;
      forever begin
         @(posedge clk);
         #1;
         det_ack = 1'b0;
         if (!busy) req_idx = 0;
         if (!det_req) begin
            delay_left = -1;
            if (noise_en && busy && $urandom_range(0, 3) == 0) begin
               det_ack  = 1'b1;
               det_data = DATA_W'($urandom);
            end
         end else begin
            if (delay_left < 0) delay_left = (ack_delay >= 0) ? ack_delay : $urandom_range(0, 3);
            if (delay_left == 0) begin
               det_ack    = 1'b1;
               det_data   = sweep_data[req_idx % LANES];
               req_idx++;
               delay_left = -1;
            end else begin
               delay_left--;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each result handshake and checks protocol invariants.
   logic             p_valid, p_ready, p_abort, p_done, p_req, p_flush;
   logic [LANES-1:0] p_valve;
   logic [LW-1:0]    p_lane;
   logic [DATA_W-1:0] p_data;
   int               settle_cnt, flush_run, flush_runs;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         p_valid = 0; p_ready = 0; p_abort = 0; p_done = 0; p_req = 0; p_flush = 0;
         p_valve = '0; p_lane = '0; p_data = '0;
         settle_cnt = 0; flush_run = 0; flush_runs = 0;
      end else begin
         check("valve_onehot", 64'($countones(valve_o) <= 1), 1);
         if (!busy) check("idle_quiet", {valve_o, flush_o, det_req, rd_valid}, 0);
         if (p_done) check("done_pulse_width", done, 0);
         if (done) check("finish_valve", valve_o, 0);
         if (p_valid && !p_ready && !p_abort) begin
            check("hold_valid", rd_valid, 1);
            check("hold_lane", rd_lane, p_lane);
            check("hold_data", rd_data, p_data);
            check("hold_valve", valve_o, p_valve);
         end
         if (rd_valid && rd_ready && !abort) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("result_lane", rd_lane, e.lane);
               check("result_data", rd_data, e.data);
               check("push_valve", valve_o, 64'(1) << e.lane);
            end
         end
         if (valve_o != p_valve) settle_cnt = 0;
         if (valve_o != '0 && !det_req) settle_cnt++;
         if (det_req && !p_req) check("settle_length", settle_cnt, SETTLE_CYCLES);
`ifdef BRAID_COLLECT_FLUSH_EN
         if (flush_o) begin
            check("flush_valve", valve_o, 0);
            flush_run++;
         end else if (p_flush) begin
            check("flush_length", flush_run, FLUSH_CYCLES);
            flush_run = 0;
            flush_runs++;
         end
         if (done) begin
            check("flush_runs", flush_runs, LANES - 1);
            flush_runs = 0;
         end
         if (!busy) flush_runs = 0;
`else
         check("flush_tied", flush_o, 0);
`endif
         if (done) done_cnt++;
         p_valid = rd_valid; p_ready = rd_ready; p_abort = abort; p_done = done;
         p_req = det_req; p_flush = flush_o; p_valve = valve_o; p_lane = rd_lane; p_data = rd_data;
      end
   end

   task automatic queue_sweep();
      for (int l = 0; l < LANES; l++) exp_q.push_back('{l, int'(sweep_data[l])});
   endtask

   task automatic randomize_data();
      for (int l = 0; l < LANES; l++) sweep_data[l] = DATA_W'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Runs one full sweep; bp holds rd_ready low for 10 cycles of the lane-1 result.
   task automatic run_sweep(input int mode, input int delay, input bit noise, input bit bp);
      int  base_done;
      bit  got;
      int  bp_state;
      int  bp_cnt;
      queue_sweep();
      ready_mode = mode;
      ack_delay  = delay;
      noise_en   = noise;
      base_done  = done_cnt;
      got        = 1'b0;
      bp_state   = 0;
      bp_cnt     = 0;
      pulse_start();
      check("sweep_busy", busy, 1);
      check("sweep_first_valve", valve_o, 1);
      for (int c = 0; c < 3000 && !got; c++) begin
         @(posedge clk);
         #1;
         start = noise && !done && ($urandom_range(0, 7) == 0);
         if (done) got = 1'b1;
         if (bp) begin
            case (bp_state)
               0: if (det_req && valve_o == 4'b0010) begin
                     ready_mode = 2;
                     bp_state   = 1;
                  end
               1: if (rd_valid) begin
                     check("bp_lane", rd_lane, 1);
                     bp_cnt   = 1;
                     bp_state = 2;
                  end
               2: begin
                     bp_cnt++;
                     if (bp_cnt == 10) begin
                        ready_mode = 0;
                        bp_state   = 3;
                     end
                  end
               default: ;
            endcase
         end
      end
      start = 1'b0;
      check("sweep_done_seen", got, 1);
      repeat (2) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      check("done_count", done_cnt - base_done, 1);
      if (bp) check("bp_exercised", bp_state, 3);
   endtask

   initial begin
      bit hit;
      int base_done;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      rst = 1'b0;

      // Nominal sweep with fixed data and latency.
      sweep_data = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_sweep(0, 2, 1'b0, 1'b0);

      // Randomized sweeps with consumer stalls, spurious acks and stray starts.
      for (int s = 0; s < 3; s++) begin
         randomize_data();
         run_sweep(1, -1, 1'b1, 1'b0);
      end

      // Backpressure on lane 1.
      randomize_data();
      run_sweep(0, -1, 1'b0, 1'b1);

      // Abort while lane 2 is sampling, with a start on the same cycle.
      randomize_data();
      queue_sweep();
      ready_mode = 0;
      ack_delay  = 3;
      noise_en   = 1'b0;
      hit        = 1'b0;
      pulse_start();
      for (int c = 0; c < 2000 && !hit; c++) begin
         @(posedge clk);
         #1;
         if (det_req && valve_o == 4'b0100) begin
            abort = 1'b1;
            start = 1'b1;
            hit   = 1'b1;
         end
      end
      check("abort_reached", hit, 1);
      base_done = done_cnt;
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
      check("abort_outputs", {busy, valve_o, flush_o, det_req, rd_valid, done}, 0);
      check("abort_pending", exp_q.size(), 2);
      exp_q.delete();
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - base_done, 0);

      // Restart after abort must begin at lane 0.
      randomize_data();
      run_sweep(0, -1, 1'b0, 1'b0);

      // Asynchronous reset during lane 3 settle.
      randomize_data();
      queue_sweep();
      ready_mode = 0;
      ack_delay  = -1;
      hit        = 1'b0;
      pulse_start();
      for (int c = 0; c < 2000 && !hit; c++) begin
         @(posedge clk);
         #1;
         if (busy && valve_o == 4'b1000 && !det_req && !rd_valid) hit = 1'b1;
      end
      check("reset_point_reached", hit, 1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      check("reset_pending", exp_q.size(), 1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // First sweep after reset release starts fresh at lane 0.
      randomize_data();
      run_sweep(1, -1, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
